// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the core-to-cache request/response link; reads answer LATENCY cycles after accept.
// Macro DMEM_WRITE_EN enables writes; without it storage is a read-only image fixed at elaboration.
module data_mem_responder #(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqcyc,
  input  logic [63:0] req,
  input  logic [12:0] reqtag,
  output logic        reqack,
  output logic        respcyc,
  output logic [63:0] resp,
  output logic [12:0] resptag,
  input  logic        respack
);

  typedef enum logic [1:0] {IDLE, WDATA, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [12:0]           tag_q, tag_d;
  logic                  resp_seen_q;
  logic                  mem_we;
  logic [63:0]           rd_word;

  // Byte offset and bits above the word index are don't-care, so addresses alias.
  logic unused_req_bits;
  assign unused_req_bits = ^{req[2:0], req[63:DEPTH_LOG2+3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
      resp_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      resp_seen_q <= (state_q == RESP);
    end
  end

`ifdef DMEM_WRITE_EN
  logic [63:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= req;
  end

  assign rd_word = mem[idx_q];
`else
  function automatic logic [63:0] image_word(input logic [DEPTH_LOG2-1:0] idx);
    return 64'hFEED_FACE_0000_0000 | 64'(idx);
  endfunction

  logic unused_we;
  assign unused_we = mem_we;
  assign rd_word   = image_word(idx_q);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    reqack  = 1'b0;
    mem_we  = 1'b0;
    respcyc = 1'b0;
    resp    = '0;
    resptag = '0;
    case (state_q)
      IDLE: begin
        if (reqcyc) begin
          reqack = 1'b1;
          idx_d  = req[DEPTH_LOG2+2:3];
          tag_d  = reqtag;
          if (reqtag[12]) begin
            cnt_d   = WAIT_LOAD;
            state_d = (LATENCY == 1) ? RESP : WAIT;
          end else begin
            state_d = WDATA;
          end
        end
      end
      WDATA: begin
        if (reqcyc) begin
          reqack  = 1'b1;
          mem_we  = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        respcyc = 1'b1;
        resp    = rd_word;
        resptag = tag_q;
        // The first RESP cycle cannot retire; an ack left over from before is stale.
        if (respack && resp_seen_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      reqack  = 1'b0;
      mem_we  = 1'b0;
      respcyc = 1'b0;
      resp    = '0;
      resptag = '0;
    end
  end

endmodule
